// File: rtl/spatz_pkg.sv
// Shared VRF types for the Spatz vector unit: register addressing, data/byte-enable
// words, and the write-back buffer entry format.
package spatz_pkg;

  localparam int unsigned NRVREG    = 32;
  localparam int unsigned VRegIdxW  = $clog2(NRVREG);
  localparam int unsigned VRegOffW  = 3;
  localparam int unsigned VRegAddrW = VRegIdxW + VRegOffW;
  localparam int unsigned ELEN      = 64;
  localparam int unsigned ELENB     = ELEN / 8;

  typedef logic [VRegAddrW-1:0] vreg_addr_t;
  typedef logic [ELEN-1:0]      vreg_data_t;
  typedef logic [ELENB-1:0]     vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wbuf_entry_t;

  // The register number lives in the top bits of a VRF word address.
  function automatic logic [VRegIdxW-1:0] vreg_idx(input vreg_addr_t addr);
    return addr[VRegAddrW-1 -: VRegIdxW];
  endfunction

endpackage

// File: rtl/spatz_vrf_wbuf_hazard.sv
// Read-after-write hazard detector: flags when any valid buffered entry targets the
// register number being checked by issue.
module spatz_vrf_wbuf_hazard #(
  parameter int unsigned Depth = 4,
  parameter int unsigned RegW  = 5
) (
  input  logic [Depth-1:0][RegW-1:0] reg_i,
  input  logic [Depth-1:0]           valid_i,
  input  logic [RegW-1:0]            chk_reg_i,
  output logic                       hazard_o
);

  always_comb begin
    hazard_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_i[i] && (reg_i[i] == chk_reg_i)) hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/spatz_vrf_wbuf.sv
// VRF write-back buffer: queues producer results and replays them in order until the
// write port grants them. Define SPATZ_VRF_WBUF_MERGE_EN to merge same-address writes.
module spatz_vrf_wbuf
  import spatz_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  vreg_addr_t          waddr_i,
  input  vreg_data_t          wdata_i,
  input  vreg_be_t            wbe_i,
  output logic                we_o,
  output vreg_addr_t          waddr_o,
  output vreg_data_t          wdata_o,
  output vreg_be_t            wbe_o,
  input  logic                wvalid_i,
  input  logic [VRegIdxW-1:0] chk_reg_i,
  output logic                hazard_o,
  output logic                empty_o,
  output logic                commit_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : gen_depth_check
    $error("spatz_vrf_wbuf: Depth must be a power of two and at least 2");
  end

  vrf_wbuf_entry_t                  mem_q [Depth];
  logic [PtrW-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                  count_q, count_d;
  logic                             full, merge_hit, push, alloc, retire;
  logic [Depth-1:0]                 valid_mask;
  logic [Depth-1:0][PtrW-1:0]       entry_off;
  logic [Depth-1:0][VRegIdxW-1:0]   entry_reg;
  vrf_wbuf_entry_t                  head_entry;

  assign full = (count_q == CntW'(Depth));

`ifdef SPATZ_VRF_WBUF_MERGE_EN
  logic [PtrW-1:0] tail_last;
  vrf_wbuf_entry_t merged;

  assign tail_last = tail_q - PtrW'(1);
  // The tail may not absorb a write while it is also the head leaving this cycle.
  assign merge_hit = (count_q != '0) && (mem_q[tail_last].addr == waddr_i)
                     && !((count_q == CntW'(1)) && wvalid_i);

  always_comb begin
    merged = mem_q[tail_last];
    for (int unsigned b = 0; b < ELENB; b++) begin
      if (wbe_i[b]) merged.data[8*b +: 8] = wdata_i[8*b +: 8];
    end
    merged.be = mem_q[tail_last].be | wbe_i;
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign ready_o  = !rst_i && !flush_i && (!full || merge_hit);
  assign push     = valid_i && ready_o;
  assign alloc    = push && !merge_hit;
  assign we_o     = (count_q != '0);
  assign retire   = we_o && wvalid_i;
  assign commit_o = retire;
  assign empty_o  = (count_q == '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc)  tail_d = tail_q + PtrW'(1);
      if (retire) head_d = head_q + PtrW'(1);
      case ({alloc, retire})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (alloc) mem_q[tail_q] <= '{addr: waddr_i, data: wdata_i, be: wbe_i};
`ifdef SPATZ_VRF_WBUF_MERGE_EN
    else if (push) mem_q[tail_last] <= merged;
`endif
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      entry_off[i]  = PtrW'(i) - head_q;
      valid_mask[i] = (CntW'(entry_off[i]) < count_q);
      entry_reg[i]  = vreg_idx(mem_q[i].addr);
    end
  end

  assign head_entry = we_o ? mem_q[head_q] : '0;
  assign waddr_o    = head_entry.addr;
  assign wdata_o    = head_entry.data;
  assign wbe_o      = head_entry.be;

  spatz_vrf_wbuf_hazard #(
    .Depth (Depth),
    .RegW  (VRegIdxW)
  ) i_hazard (
    .reg_i     (entry_reg),
    .valid_i   (valid_mask),
    .chk_reg_i (chk_reg_i),
    .hazard_o  (hazard_o)
  );

endmodule

// File: doc/spatz_vrf_wbuf.md
# spatz_vrf_wbuf

Write-back buffer between one result producer (VFU, VLSU or slide unit) and its VRF write port. Absorbs write-port arbitration losses: results are queued in a small FIFO and replayed to the VRF until `wvalid_i` grants them, so the producer never stalls on a bank conflict until the buffer fills. It also reports read-after-write hazards on buffered registers to the issue logic.

## Interface
- `Depth`, 4: number of buffered writes; power of two, at least 2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, asynchronous, active-high.
- `flush_i`  in  1  synchronous drop of all buffered entries.
- `valid_i`  in  1  producer write request.
- `ready_o`  out  1  buffer accepts the request this cycle.
- `waddr_i`  in  vreg_addr_t  producer write address.
- `wdata_i`  in  vreg_data_t  producer write data.
- `wbe_i`  in  vreg_be_t  producer byte enables.
- `we_o`  out  1  VRF write request (head entry valid).
- `waddr_o`  out  vreg_addr_t  head address.
- `wdata_o`  out  vreg_data_t  head data.
- `wbe_o`  out  vreg_be_t  head byte enables.
- `wvalid_i`  in  1  VRF grant for `we_o`.
- `chk_reg_i`  in  $clog2(NRVREG)  register number to check for pending writes.
- `hazard_o`  out  1  some buffered entry targets `chk_reg_i`.
- `empty_o`  out  1  no buffered entries.
- `commit_o`  out  1  head entry retired this cycle.

## Operation
- Circular FIFO: head/tail pointers `$clog2(Depth)` bits, wrap modulo Depth; occupancy count `$clog2(Depth+1)` bits.
- Push: `valid_i && ready_o`. Entry stored at tail, tail increments, count increments.
- `ready_o = !rst_i && !flush_i && (count < Depth)`. No pass-through when full, even if the head retires the same cycle.
- Present: `we_o = (count != 0)`. `waddr_o`, `wdata_o` and `wbe_o` come from the head entry. Outputs are zero when empty.
- Retire: `we_o && wvalid_i`. Head increments, count decrements, `commit_o = 1`. A grant while empty is ignored.
- Simultaneous push and retire: count is unchanged and both pointers advance.
- Flush:
  - Pointers and count go to 0 the next cycle.
  - A retire in the flush cycle still asserts `commit_o`, because the VRF wrote it.
  - A push in the flush cycle is refused (`ready_o = 0`).
- Hazard: `hazard_o` is high if any valid entry's register field (top `$clog2(NRVREG)` bits of the address) equals `chk_reg_i`. This is combinational over stored entries only and excludes the in-flight `waddr_i`.
- Entries are written to the VRF strictly in push order.

## Timing
- Reset values:
  - `we_o=0`, `commit_o=0`, `hazard_o=0`, `empty_o=1`.
  - `ready_o=0` while `rst_i` is high, and 1 in the first cycle after release.
  - Address, data and BE outputs are 0.
- Reset mid-operation discards all entries immediately (asynchronous). No `commit_o` is generated for them.
- Latency: an entry pushed in cycle N is presented on `we_o` in cycle N+1 at the earliest (registered, no bypass).
- `commit_o` is combinational in the grant cycle; the entry is gone in cycle N+1.
- Throughput: one push and one retire per cycle.
- `wdata_o`, `waddr_o` and `wbe_o` stay stable while `we_o && !wvalid_i`, with one exception: a merge into the head entry (Configuration) may change `wbe_o`/`wdata_o`.

## Configuration
- `SPATZ_VRF_WBUF_MERGE_EN` defined:
  - An incoming write whose full address equals the tail entry's address is merged into that entry instead of allocating a new one.
  - For each byte where `wbe_i` is set, the new data overwrites the old. The entry's BE becomes the OR of old and new.
  - Merge is allowed only when the tail entry is not the head being granted this cycle (`!(count==1 && wvalid_i)`).
  - A merge is accepted even when full; in that case `ready_o = 1`.
  - Count is unchanged by a merge.
- Undefined: every accepted write allocates an entry. There is no address compare on the tail.

## Structure
- `vreg_addr_t`, `vreg_data_t`, `vreg_be_t` and `NRVREG` come from `spatz_pkg`. Add a `vrf_wbuf_entry_t` struct (addr, data, be) there.
- One sub-module: `spatz_vrf_wbuf_hazard`, a parameterised compare/OR-reduce of entry register fields against `chk_reg_i`, masked by valid bits.
- Elaboration `$error` if `Depth` < 2 or `Depth` is not a power of two.

## Test plan
- Push 4 writes (reg 1..4), `wvalid_i=0` → `ready_o=0` after the 4th. Then `wvalid_i=1` for 4 cycles → commits reg 1,2,3,4 in order, `empty_o=1`.
- Push one write in cycle 0 with `wvalid_i` held at 1 → `we_o` rises in cycle 1, `commit_o=1` in cycle 1, `empty_o=1` in cycle 2.
- Full buffer with push and grant in the same cycle → push refused, count 3. Next cycle: push accepted, count 4.
- Buffer entries at reg 5 and reg 7 → `chk_reg_i=7` gives `hazard_o=1`, `chk_reg_i=6` gives `hazard_o=0`. After reg 7 commits, `chk_reg_i=7` gives 0.
- `flush_i` with 3 entries and a concurrent grant → `commit_o=1` that cycle, `empty_o=1` next cycle, and the push in that cycle is refused.
- With the macro defined: two writes to the same address, BE `0x0F` then `0xF0` → one entry with BE `0xFF` and merged data; a single commit.
- Assert `rst_i` mid-stream → `we_o` drops immediately. After release, `ready_o=1` and no stale commit occurs.
